// File: rtl/toeplitz_pkg.sv
// Shared configuration for the deserializer: default word length, default
// mid-word idle tolerance and the FSM state encoding.
package toeplitz_pkg;

    localparam int DEFAULT_L       = 128;
    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic {
        IDLE    = 1'b0,  // no partial word held, bit counter at 0
        COLLECT = 1'b1   // 1..L-1 bits of the current word held
    } state_t;

endpackage

// File: rtl/deser_gap_timer.sv
// Idle-gap watchdog for a partially assembled word. Counts qbiten=0 cycles
// while the deserializer is busy and flags the cycle that would complete the
// TIMEOUT-th consecutive idle cycle. The owning edge discards the word.
// Only instantiated when DESERIALIZER_TIMEOUT_EN is defined.
module deser_gap_timer
    import toeplitz_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    input  logic qbiten,
    output logic timeout
);

    // Counter only needs to reach TIMEOUT-1: the TIMEOUT-th idle cycle is
    // recognised combinationally so the discard lands on that same edge.
    localparam int GW = $clog2(TIMEOUT);

    logic [GW-1:0] gap_cnt;

    assign timeout = busy && !qbiten && (gap_cnt == GW'(TIMEOUT - 1));

    // Idle-cycle counter: cleared by any accepted bit, outside COLLECT, or on expiry.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (!busy || qbiten || timeout) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel converter, MSB first. One bit is accepted per clock with
// qbiten=1; after L bits the word is loaded into y and ystrobe pulses in the
// following cycle. Optional feature macro DESERIALIZER_TIMEOUT_EN enables the
// mid-word gap timer: a partial word idle for TIMEOUT cycles is discarded and
// terr pulses. Without the macro, partial words survive arbitrary gaps.
module deserializer
    import toeplitz_pkg::*;
#(
    parameter int L       = DEFAULT_L,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         qbit,
    input  logic         qbiten,
    output logic [L-1:0] y,
    output logic         ystrobe,
    output logic         terr,
    output logic         busy
);

    localparam int CW = $clog2(L);

    state_t          state, next_state;
    logic [CW-1:0]   bit_cnt;
    // Holds the first L-1 bits; the L-th bit goes straight into y together
    // with them, so the word is never assembled a cycle late.
    logic [L-2:0]    shreg;
    logic [L-1:0]    shreg_next;
    logic            last_bit;
    logic            timeout;

    assign shreg_next = {shreg, qbit};
    assign last_bit   = qbiten && (bit_cnt == CW'(L - 1));
    assign busy       = (state == COLLECT);

`ifdef DESERIALIZER_TIMEOUT_EN
    deser_gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .clk     (clk),
        .reset   (reset),
        .busy    (busy),
        .qbiten  (qbiten),
        .timeout (timeout)
    );

    // Error pulse in the cycle after a partial word is discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            terr <= 1'b0;
        end else begin
            terr <= timeout;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign terr               = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT != 0);
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: enter COLLECT on the first bit, leave on the L-th bit or timeout.
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (qbiten)              next_state = COLLECT;
            COLLECT: if (last_bit || timeout) next_state = IDLE;
            default:                          next_state = IDLE;
        endcase
    end

    // Datapath: shift accepted bits, count them, publish the finished word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt <= '0;
            shreg   <= '0;
            y       <= '0;
            ystrobe <= 1'b0;
        end else begin
            ystrobe <= 1'b0;
            if (qbiten) begin
                shreg <= shreg_next[L-2:0];
                if (last_bit) begin
                    y       <= shreg_next;
                    ystrobe <= 1'b1;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (timeout) begin
                // Stale shreg bits are harmless: a new word overwrites all of them.
                bit_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer (L=128, TIMEOUT=16). The driver pushes
// each word it fully serializes into exp_q; a negedge monitor pops and
// compares whenever ystrobe is seen. Timeout scenarios follow whichever
// build of DESERIALIZER_TIMEOUT_EN the bench is compiled with.
`timescale 1ns/1ps
module tb_deserializer;

    localparam int L       = 128;
    localparam int TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         qbit;
    logic         qbiten;
    logic [L-1:0] y;
    logic         ystrobe;
    logic         terr;
    logic         busy;

    int           vectors     = 0;
    int           miscompares = 0;
    int           cyc         = 0;
    int           last_stb    = 0;
    int           prev_stb    = 0;
    int           exp_terr    = 0;
    logic [L-1:0] exp_q[$];

    localparam logic [L-1:0] W_MAIN = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [L-1:0] W_ONES = {L{1'b1}};
    localparam logic [L-1:0] W_ZERO = '0;
    localparam logic [L-1:0] W_A5   = {16{8'hA5}};
    localparam logic [L-1:0] W_ALT  = 128'h1122334455667788_99AABBCCDDEEFF00;
    localparam logic [L-1:0] W_POST = 128'hDEADBEEFCAFEF00D_0F1E2D3C4B5A6978;

    deserializer #(
        .L       (L),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .qbit    (qbit),
        .qbiten  (qbiten),
        .y       (y),
        .ystrobe (ystrobe),
        .terr    (terr),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [L-1:0] act, input logic [L-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Serialize bits [from, to) of w, MSB first, one per clock.
    task automatic send_bits(input logic [L-1:0] w, input int from, input int to);
        logic [L-1:0] word;
        word = w;
        for (int i = from; i < to; i++) begin
            qbit   = word[L-1-i];
            qbiten = 1'b1;
            @(posedge clk);
            #1;
        end
        qbiten = 1'b0;
        qbit   = 1'b0;
    endtask

    task automatic idle(input int n);
        qbiten = 1'b0;
        qbit   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every strobe must match the oldest expected word; every terr must be anticipated.
    always @(negedge clk) begin
        if (!reset) begin
            if (ystrobe || terr) begin
                check("strobe_terr_exclusive", {127'b0, ystrobe & terr}, '0);
            end
            if (ystrobe) begin
                check("ystrobe_expected", {127'b0, ystrobe}, {127'b0, exp_q.size() != 0});
                if (exp_q.size() != 0) begin
                    check("y_word", y, exp_q.pop_front());
                end
                prev_stb = last_stb;
                last_stb = cyc;
            end
            if (terr) begin
                check("terr_expected", {127'b0, terr}, {127'b0, exp_terr != 0});
                if (exp_terr != 0) exp_terr--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        qbit   = 1'b0;
        qbiten = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_y",       y,                  '0);
        check("reset_ystrobe", {127'b0, ystrobe},  '0);
        check("reset_terr",    {127'b0, terr},     '0);
        check("reset_busy",    {127'b0, busy},     '0);
        reset = 1'b0;
        idle(2);

        // Single word, strobe one cycle after the last bit edge.
        exp_q.push_back(W_MAIN);
        send_bits(W_MAIN, 0, L);
        check("strobe_latency", {127'b0, ystrobe}, 128'd1);
        check("busy_after_word", {127'b0, busy}, '0);
        idle(1);
        check("strobe_one_cycle", {127'b0, ystrobe}, '0);
        check("y_holds", y, W_MAIN);
        idle(2);

        // Back-to-back words: strobes exactly L cycles apart.
        exp_q.push_back(W_ONES);
        exp_q.push_back(W_ZERO);
        send_bits(W_ONES, 0, L);
        send_bits(W_ZERO, 0, L);
        idle(2);
        check("b2b_spacing", L'(last_stb - prev_stb), L'(L));

        // Gap one cycle short of the timeout must not disturb assembly.
        exp_q.push_back(W_A5);
        send_bits(W_A5, 0, 64);
        idle(TIMEOUT - 1);
        check("busy_mid_gap", {127'b0, busy}, 128'd1);
        send_bits(W_A5, 64, L);
        idle(2);
        check("y_after_short_gap", y, W_A5);

`ifdef DESERIALIZER_TIMEOUT_EN
        // Gap of TIMEOUT cycles discards the partial word.
        send_bits(W_ALT, 0, 64);
        exp_terr = 1;
        idle(TIMEOUT);
        check("terr_pulse", {127'b0, terr}, 128'd1);
        check("busy_after_timeout", {127'b0, busy}, '0);
        check("y_unchanged_timeout", y, W_A5);
        idle(1);
        check("terr_one_cycle", {127'b0, terr}, '0);
        check("terr_seen", L'(exp_terr), '0);
        exp_q.push_back(W_ALT);
        send_bits(W_ALT, 0, L);
        idle(2);
`else
        // Without the gap timer a long pause is harmless.
        exp_q.push_back(W_ALT);
        send_bits(W_ALT, 0, 64);
        idle(100);
        check("busy_long_gap", {127'b0, busy}, 128'd1);
        check("terr_tied_low", {127'b0, terr}, '0);
        send_bits(W_ALT, 64, L);
        idle(2);
        check("y_after_long_gap", y, W_ALT);
`endif

        // Reset mid-word: immediate clear, no strobe, next word clean.
        send_bits(W_MAIN, 0, 40);
        check("busy_before_reset", {127'b0, busy}, 128'd1);
        reset = 1'b1;
        #1;
        check("async_reset_y",    y,                 '0);
        check("async_reset_busy", {127'b0, busy},    '0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1);
        check("post_reset_busy", {127'b0, busy}, '0);
        exp_q.push_back(W_POST);
        send_bits(W_POST, 0, L);
        idle(3);
        check("y_after_reset", y, W_POST);

        check("scoreboard_drained", L'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 Parameter L, default 128, SHALL be the word length in bits, L >= 2.
REQ-002 Parameter TIMEOUT, default 16, SHALL be the maximum idle-cycle gap tolerated mid-word, TIMEOUT >= 2.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, SHALL be the asynchronous, active-high reset.
REQ-005 Port qbit, input, 1, SHALL carry serial data; sampled only when qbiten=1.
REQ-006 Port qbiten, input, 1, SHALL qualify qbit; one bit accepted per clock with qbiten=1.
REQ-007 Port y, output, L, SHALL hold the last completed word.
REQ-008 Port ystrobe, output, 1, SHALL pulse for one cycle when y is updated.
REQ-009 Port terr, output, 1, SHALL pulse for one cycle when a partial word is discarded by timeout.
REQ-010 Port busy, output, 1, SHALL be high while a partial word is held (state COLLECT).

Function
REQ-011 Bit order SHALL be MSB first: the first accepted bit of a word lands in y[L-1], the L-th in y[0].
REQ-012 Accepted bits SHALL shift into an internal L-bit register; a bit counter SHALL count 0..L-1.
REQ-013 The FSM SHALL have states IDLE (counter 0, no partial word) and COLLECT (1..L-1 bits held).
REQ-014 IDLE -> COLLECT SHALL occur on the first accepted bit; COLLECT -> IDLE on the L-th accepted bit or on timeout.
REQ-015 On the edge accepting the L-th bit, y SHALL load the full word and ystrobe SHALL be 1 in the following cycle only (latency: 1 cycle after last bit edge).
REQ-016 A bit accepted on the cycle after completion SHALL start the next word with no lost cycle; back-to-back words SHALL give ystrobe every L cycles.
REQ-017 y SHALL hold its value until the next completed word; it SHALL NOT change on timeout.
REQ-018 Gaps (qbiten=0) of fewer than TIMEOUT cycles in COLLECT SHALL NOT affect assembly.
REQ-019 Gap counter SHALL clear on every accepted bit and count cycles with qbiten=0 in COLLECT only.
REQ-020 When the gap counter reaches TIMEOUT, the partial word SHALL be discarded, counter cleared, FSM -> IDLE, terr=1 for the next cycle only.
REQ-021 ystrobe and terr SHALL never be high in the same cycle.

Reset
REQ-022 Reset SHALL force y=0, ystrobe=0, terr=0, busy=0, FSM=IDLE, bit and gap counters=0, immediately and asynchronously.
REQ-023 Reset mid-word SHALL discard the partial word with no ystrobe and no terr; first bit after reset release starts a new word.

Configuration
REQ-024 Macro DESERIALIZER_TIMEOUT_EN defined: REQ-019/020 gap timer active.
REQ-025 Macro undefined: no gap timer, terr tied 0, partial words persist across arbitrary gaps; TIMEOUT ignored.

Structure
REQ-026 Package toeplitz_pkg SHALL hold default L, default TIMEOUT and the FSM state enum (IDLE, COLLECT).
REQ-027 The gap timer SHALL be a sub-module deser_gap_timer (inputs clk, reset, busy, qbiten; output timeout pulse), instantiated only under DESERIALIZER_TIMEOUT_EN.

Verification
REQ-028 Bench (L=128, TIMEOUT=16, macro on, toeplitz serializer as driver) SHALL cover:
- Serializer driven with q=128'h0123456789ABCDEF_FEDCBA9876543210 + qstrobe -> ystrobe once, y equal bit-for-bit, terr=0.
- Two words back-to-back (128'hFFFF..., then 128'h0) -> two ystrobes exactly 128 cycles apart, y correct each time.
- 64 bits, 15-cycle gap, remaining 64 bits of 128'hA5A5...A5 -> y=128'hA5A5...A5, no terr.
- 64 bits, 16-cycle gap -> terr pulse 1 cycle, busy=0, y unchanged; next full word assembles correctly.
- Reset asserted after 40 bits -> y=0, busy=0 immediately; no ystrobe/terr; following word correct.
- Macro off, 64 bits, 100-cycle gap, 64 bits -> ystrobe once, correct word, terr stays 0.
